// File: rtl/key_event_sequencer.sv
// PS/2 scancode sequencer: decodes make/break/extended bytes, tracks Shift, filters
// typematic repeats, looks presses up in a synchronous ROM and queues the ASCII events.
module key_event_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    output logic       rom_rd,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       key_valid,
    output logic [7:0] key_ascii,
    output logic       key_extended,
    input  logic       key_ready,
    output logic       shift_held,
    output logic       overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [2:0] {IDLE, PRE_E0, BRK, BRK_E0, LOOKUP, PUSH} state_t;

    state_t          r_state, w_state_nx;
    logic            r_shift, w_shift_nx;
    logic [7:0]      r_last_make, w_last_make_nx;
    logic            r_last_ext, w_last_ext_nx;
    logic [7:0]      r_rom_addr, w_rom_addr_nx;
    logic            r_cur_ext, w_cur_ext_nx;
    logic            r_hold_vld, w_hold_vld_nx;
    logic [7:0]      r_hold, w_hold_nx;
    logic            r_overflow;

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_byte_vld, w_is_shift, w_repeat;
    logic [7:0]      w_byte, w_ascii;
    logic            w_make, w_make_ext, w_hold_lost, w_push;
    logic            w_pop, w_full, w_wr, w_drop;

    // A held byte always takes priority over the live strobe so byte order is kept.
    assign w_byte_vld = r_hold_vld | ps2_ready;
    assign w_byte     = r_hold_vld ? r_hold : ps2_data;
    assign w_is_shift = (w_byte == SC_LSHIFT) || (w_byte == SC_RSHIFT);
    assign w_repeat   = REPEAT_FILTER && (w_byte == r_last_make) && (w_make_ext == r_last_ext);

    always_comb begin
        w_state_nx     = r_state;
        w_shift_nx     = r_shift;
        w_last_make_nx = r_last_make;
        w_last_ext_nx  = r_last_ext;
        w_rom_addr_nx  = r_rom_addr;
        w_cur_ext_nx   = r_cur_ext;
        w_hold_vld_nx  = r_hold_vld;
        w_hold_nx      = r_hold;
        w_hold_lost    = 1'b0;
        w_make         = 1'b0;
        w_make_ext     = 1'b0;
        w_push         = 1'b0;

        if (r_state == LOOKUP || r_state == PUSH) begin
            if (ps2_ready) begin
                if (r_hold_vld) begin
                    w_hold_lost = 1'b1;
                end else begin
                    w_hold_vld_nx = 1'b1;
                    w_hold_nx     = ps2_data;
                end
            end
        end else if (r_hold_vld) begin
            w_hold_vld_nx = ps2_ready;
            if (ps2_ready) w_hold_nx = ps2_data;
        end

        case (r_state)
            IDLE: begin
                if (w_byte_vld) begin
                    if (w_byte == SC_E0)      w_state_nx = PRE_E0;
                    else if (w_byte == SC_F0) w_state_nx = BRK;
                    else                      w_make = 1'b1;
                end
            end
            PRE_E0: begin
                if (w_byte_vld) begin
                    if (w_byte == SC_F0) begin
                        w_state_nx = BRK_E0;
                    end else begin
                        w_make     = 1'b1;
                        w_make_ext = 1'b1;
                    end
                end
            end
            BRK, BRK_E0: begin
                if (w_byte_vld) begin
                    if (r_state == BRK && w_is_shift) w_shift_nx = 1'b0;
                    if (w_byte == r_last_make && (r_state == BRK_E0) == r_last_ext)
                        w_last_make_nx = 8'h00;
                    w_state_nx = IDLE;
                end
            end
            LOOKUP: w_state_nx = PUSH;
            PUSH: begin
                w_push     = (rom_data != 8'h00);
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase

        if (w_make) begin
            w_state_nx = IDLE;
            if (!w_make_ext && w_is_shift) begin
                w_shift_nx = 1'b1;
            end else if (!w_repeat) begin
                w_last_make_nx = w_byte;
                w_last_ext_nx  = w_make_ext;
                w_rom_addr_nx  = w_byte;
                w_cur_ext_nx   = w_make_ext;
                w_state_nx     = LOOKUP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= 1'b0;
            r_last_make <= 8'h00;
            r_last_ext  <= 1'b0;
            r_rom_addr  <= 8'h00;
            r_cur_ext   <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold      <= 8'h00;
            r_overflow  <= 1'b0;
        end else begin
            r_shift     <= w_shift_nx;
            r_last_make <= w_last_make_nx;
            r_last_ext  <= w_last_ext_nx;
            r_rom_addr  <= w_rom_addr_nx;
            r_cur_ext   <= w_cur_ext_nx;
            r_hold_vld  <= w_hold_vld_nx;
            r_hold      <= w_hold_nx;
            r_overflow  <= r_overflow | w_hold_lost | w_drop;
        end
    end

    // Shift only uppercases letters; digits and symbols pass through unchanged.
    assign w_ascii = (r_shift && rom_data >= 8'h61 && rom_data <= 8'h7A) ? (rom_data - 8'h20) : rom_data;

    assign w_pop  = key_valid && key_ready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= {r_cur_ext, w_ascii};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rom_rd       = (r_state == LOOKUP);
    assign rom_addr     = r_rom_addr;
    assign key_valid    = (r_count != '0);
    assign key_ascii    = r_mem[r_rptr][7:0];
    assign key_extended = r_mem[r_rptr][8];
    assign shift_held   = r_shift;
    assign overflow     = r_overflow;
endmodule

// File: tb/tb_key_event_sequencer.sv
// Bench for key_event_sequencer: a filtered and an unfiltered instance share one byte
// stream; popped events are compared with a keyboard-level reference model.
module tb_key_event_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       key_ready = 1'b0;
    logic       rom_rd_a, rom_rd_b, key_valid_a, key_valid_b, key_ext_a, key_ext_b;
    logic       shift_a, shift_b, ovf_a, ovf_b;
    logic [7:0] rom_addr_a, rom_addr_b, key_ascii_a, key_ascii_b;
    logic [7:0] rom_data_a = 8'h00, rom_data_b = 8'h00;
    logic [7:0] rom_mem [256];
    int         checks = 0, errors = 0;
    logic [8:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    // reference keyboard state; index 0 = repeat filter on, 1 = off
    bit         m_e0[2], m_brk[2], m_shift[2], m_last_ext[2];
    logic [7:0] m_last[2];

    key_event_sequencer #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b1)) dut_a (
        .clk(clk), .reset(reset), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .rom_rd(rom_rd_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .key_valid(key_valid_a), .key_ascii(key_ascii_a), .key_extended(key_ext_a),
        .key_ready(key_ready), .shift_held(shift_a), .overflow(ovf_a));

    key_event_sequencer #(.FIFO_DEPTH(4), .REPEAT_FILTER(1'b0)) dut_b (
        .clk(clk), .reset(reset), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .rom_rd(rom_rd_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .key_valid(key_valid_b), .key_ascii(key_ascii_b), .key_extended(key_ext_b),
        .key_ready(key_ready), .shift_held(shift_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_rd_a) rom_data_a <= rom_mem[rom_addr_a];
        if (rom_rd_b) rom_data_b <= rom_mem[rom_addr_b];
    end

    // inputs only change 1 time unit after posedge, so negedge sees what the next edge uses
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid_a && key_ready) got_a.push_back({key_ext_a, key_ascii_a});
            if (key_valid_b && key_ready) got_b.push_back({key_ext_b, key_ascii_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_make(input int k, input logic [7:0] b, input bit ext);
        logic [7:0] a;
        if (!ext && (b == 8'h12 || b == 8'h59)) begin
            m_shift[k] = 1'b1;
        end else if (!(k == 0 && b == m_last[k] && ext == m_last_ext[k])) begin
            m_last[k]     = b;
            m_last_ext[k] = ext;
            a = rom_mem[b];
            if (a != 8'h00) begin
                if (m_shift[k] && a inside {[8'h61:8'h7A]}) a = a - 8'h20;
                if (k == 0) exp_a.push_back({ext, a});
                else        exp_b.push_back({ext, a});
            end
        end
    endtask

    task automatic model_byte(input int k, input logic [7:0] b);
        if (m_brk[k]) begin
            if (!m_e0[k] && (b == 8'h12 || b == 8'h59)) m_shift[k] = 1'b0;
            if (b == m_last[k] && m_e0[k] == m_last_ext[k]) m_last[k] = 8'h00;
            m_brk[k] = 1'b0;
            m_e0[k]  = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk[k] = 1'b1;
        end else if (b == 8'hE0 && !m_e0[k]) begin
            m_e0[k] = 1'b1;
        end else begin
            model_make(k, b, m_e0[k]);
            m_e0[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_e0[k] = 0; m_brk[k] = 0; m_shift[k] = 0; m_last_ext[k] = 0; m_last[k] = 8'h00;
        end
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        ps2_ready = 1'b1;
        ps2_data  = b;
        model_byte(0, b);
        model_byte(1, b);
        tick();
        ps2_ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input string name);
        int n;
        key_ready = 1'b1;
        repeat (6) tick();
        n = 0;
        while ((key_valid_a || key_valid_b) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (key_valid_a || key_valid_b) begin
            errors++;
            $display("FAIL %s drain: queue still valid after %0d cycles, required empty", name, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({key_valid_a, key_ascii_a, key_ext_a, rom_rd_a, rom_addr_a, shift_a, ovf_a} !== 21'd0 ||
            {key_valid_b, key_ascii_b, key_ext_b, rom_rd_b, rom_addr_b, shift_b, ovf_b} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: a=%h b=%h required 0", {key_valid_a, key_ascii_a, key_ext_a,
                     rom_rd_a, rom_addr_a, shift_a, ovf_a}, {key_valid_b, key_ascii_b, key_ext_b,
                     rom_rd_b, rom_addr_b, shift_b, ovf_b});
        end
    endtask

    task automatic test_latency();
        do_reset();
        key_ready = 1'b0;
        send_byte(8'h1C, 0);
        @(negedge clk);
        checks++;
        if (rom_rd_a !== 1'b1 || rom_addr_a !== 8'h1C) begin
            errors++;
            $display("FAIL latency_rom T+1: rom_rd=%b addr=%h required 1/1c", rom_rd_a, rom_addr_a);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rom_rd_a !== 1'b0 || key_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_t2: rom_rd=%b key_valid=%b required 0/0", rom_rd_a, key_valid_a);
        end
        tick();
        @(negedge clk);
        checks++;
        if (key_valid_a !== 1'b1 || key_ascii_a !== 8'h61 || key_ext_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_t3: valid=%b ascii=%h ext=%b required 1/61/0", key_valid_a, key_ascii_a, key_ext_a);
        end
        tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (key_valid_a !== 1'b0 || got_a.size() != 1) begin
            errors++;
            $display("FAIL latency_pop: valid=%b popped=%0d required 0/1", key_valid_a, got_a.size());
        end
    endtask

    task automatic test_shift();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h12, 4);
        @(negedge clk);
        checks++;
        if (shift_a !== 1'b1 || shift_b !== 1'b1) begin
            errors++;
            $display("FAIL shift_set: shift_held=%b/%b required 1", shift_a, shift_b);
        end
        send_byte(8'h1C, 4); send_byte(8'hF0, 4); send_byte(8'h1C, 4);
        send_byte(8'hF0, 4); send_byte(8'h12, 4);
        @(negedge clk);
        checks++;
        if (shift_a !== 1'b0 || shift_b !== 1'b0) begin
            errors++;
            $display("FAIL shift_clear: shift_held=%b/%b required 0", shift_a, shift_b);
        end
        drain("shift");
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 9'h041) begin
            errors++;
            $display("FAIL shift_event: count=%0d first=%h required 1 event 041", got_a.size(),
                     got_a.size() > 0 ? got_a[0] : 9'h1FF);
        end
        for (int i = 0; i < exp_b.size(); i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL shift_model_b[%0d]: got %h required %h", i, i < got_b.size() ? got_b[i] : 9'h1FF, exp_b[i]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        do_reset();
        key_ready = 1'b1;
        foreach (seq[i]) send_byte(seq[i], 4);
        drain("repeat");
        checks++;
        if (got_a.size() != 2 || got_b.size() != 4) begin
            errors++;
            $display("FAIL repeat_counts: filtered=%0d unfiltered=%0d required 2/4", got_a.size(), got_b.size());
        end
        for (int i = 0; i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== 9'h061) begin
                errors++;
                $display("FAIL repeat_value[%0d]: got %h required 061", i, got_a[i]);
            end
        end
        checks++;
        if (exp_a.size() != got_a.size() || exp_b.size() != got_b.size()) begin
            errors++;
            $display("FAIL repeat_model: got %0d/%0d required %0d/%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h07};
        do_reset();
        key_ready = 1'b1;
        foreach (seq[i]) send_byte(seq[i], 4);
        drain("extended");
        checks++;
        if (got_a.size() != 1 || got_b.size() != 1 || got_a[0] !== 9'h138 || got_b[0] !== 9'h138) begin
            errors++;
            $display("FAIL extended_event: counts %0d/%0d first %h required 1/1 138", got_a.size(), got_b.size(),
                     got_a.size() > 0 ? got_a[0] : 9'h1FF);
        end
    endtask

    task automatic test_fifo_full();
        logic [8:0] want [5] = '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065};
        do_reset();
        key_ready = 1'b0;
        send_byte(8'h1C, 4); send_byte(8'h32, 4); send_byte(8'h21, 4); send_byte(8'h23, 4);
        @(negedge clk);
        checks++;
        if (key_valid_a !== 1'b1 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL full_four: valid=%b overflow=%b/%b required 1/0/0", key_valid_a, ovf_a, ovf_b);
        end
        send_byte(8'h24, 0);
        tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: overflow=%b/%b required 0", ovf_a, ovf_b);
        end
        send_byte(8'h2B, 4);
        @(negedge clk);
        checks++;
        if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: overflow=%b/%b required 1", ovf_a, ovf_b);
        end
        drain("fifo_full");
        checks++;
        if (got_a.size() != 5 || got_b.size() != 5) begin
            errors++;
            $display("FAIL full_count: popped %0d/%0d required 5", got_a.size(), got_b.size());
        end
        for (int i = 0; i < 5 && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== want[i]) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h required %h", i, got_a[i], want[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h1C, 0);
        send_byte(8'h32, 6);
        drain("hold");
        checks++;
        if (got_a.size() != 2 || got_a[0] !== 9'h061 || got_a[1] !== 9'h062 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_one: count=%0d overflow=%b required 2 events 061,062 overflow 0", got_a.size(), ovf_a);
        end
        do_reset();
        send_byte(8'h1C, 0);
        send_byte(8'h32, 0);
        send_byte(8'h21, 6);
        drain("hold_lost");
        checks++;
        if (got_a.size() != 2 || got_a[1] !== 9'h062 || ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL hold_lost: count=%0d overflow=%b/%b required 2 events, overflow 1", got_a.size(), ovf_a, ovf_b);
        end
    endtask

    task automatic test_reset_in_push();
        bit saw_rd;
        do_reset();
        key_ready = 1'b0;
        send_byte(8'h12, 4);
        send_byte(8'h1C, 4);
        send_byte(8'h32, 0);
        send_byte(8'h21, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({key_valid_a, key_ascii_a, key_ext_a, rom_rd_a, rom_addr_a, shift_a, ovf_a} !== 21'd0) begin
            errors++;
            $display("FAIL reset_in_push: outputs=%h required 0", {key_valid_a, key_ascii_a, key_ext_a,
                     rom_rd_a, rom_addr_a, shift_a, ovf_a});
        end
        saw_rd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (rom_rd_a || rom_rd_b || key_valid_a || key_valid_b) saw_rd = 1;
        end
        checks++;
        if (saw_rd) begin
            errors++;
            $display("FAIL reset_in_push_quiet: activity after reset=%b required 0", saw_rd);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h75, 8'h07, 8'h12, 8'h59, 8'hE0, 8'hF0};
        logic [7:0] b;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
            key_ready = 1'($urandom_range(0, 1));
            ps2_ready = 1'b1;
            ps2_data  = b;
            model_byte(0, b);
            model_byte(1, b);
            tick();
            ps2_ready = 1'b0;
            key_ready = 1'($urandom_range(0, 1));
            tick();
            key_ready = 1'($urandom_range(0, 1));
            tick();
            key_ready = 1'b1;
            tick();
        end
        drain("random");
        checks++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size() || ovf_a || ovf_b) begin
            errors++;
            $display("FAIL random_counts: got %0d/%0d required %0d/%0d overflow %b/%b", got_a.size(),
                     got_b.size(), exp_a.size(), exp_b.size(), ovf_a, ovf_b);
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL random_a[%0d]: got %h required %h", i, got_a[i], exp_a[i]);
            end
        end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL random_b[%0d]: got %h required %h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(8'h20, 8'h7E));
        rom_mem[8'h1C] = 8'h61; rom_mem[8'h32] = 8'h62; rom_mem[8'h21] = 8'h63;
        rom_mem[8'h23] = 8'h64; rom_mem[8'h24] = 8'h65; rom_mem[8'h2B] = 8'h66;
        rom_mem[8'h75] = 8'h38; rom_mem[8'h07] = 8'h00;
        test_reset();
        test_latency();
        test_shift();
        test_repeat();
        test_extended();
        test_fifo_full();
        test_hold();
        test_reset_in_push();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/key_event_sequencer.md
Name: key_event_sequencer

Overview:
Controller between the PS/2 byte receiver and the scancode-to-ASCII lookup ROM. It decodes the byte stream for make, break (F0) and extended (E0) codes, tracks Shift, and suppresses typematic repeats. Only genuine key presses are looked up in the ROM; each resulting event is queued in a small FIFO with a valid/ready handshake to the clock-setting logic.

Parameters:
FIFO_DEPTH, 4, event queue entries; a power of two, at least 2.
REPEAT_FILTER, 1, 1 = drop a repeated make of the key already held; 0 = pass repeats through.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
ps2_ready  in  1  one-cycle strobe; ps2_data is valid in that cycle.
ps2_data  in  8  received scancode byte.
rom_rd  out  1  ROM read enable.
rom_addr  out  8  ROM address (scancode); registered.
rom_data  in  8  ROM data, valid the cycle after rom_rd (synchronous ROM); 0x00 = unmapped.
key_valid  out  1  FIFO not empty.
key_ascii  out  8  ASCII code at the FIFO head.
key_extended  out  1  head event came from an E0-prefixed code.
key_ready  in  1  consumer accepts the head when key_valid and key_ready are both high.
shift_held  out  1  left Shift (0x12) or right Shift (0x59) currently held.
overflow  out  1  sticky; an event or byte was lost.

Behaviour:
- Reset (synchronous, all-encompassing, takes effect mid-operation): state=IDLE, FIFO emptied, key_valid=0, key_ascii=0, key_extended=0, rom_rd=0, rom_addr=0, shift_held=0, overflow=0, last_make=0x00, last_ext=0, hold register empty.
- States: IDLE, PRE_E0, BRK, BRK_E0, LOOKUP, PUSH.
- IDLE, on a byte:
  - 0xE0 -> PRE_E0.
  - 0xF0 -> BRK.
  - Otherwise it is a make with ext=0 (see make handling).
- PRE_E0, on a byte:
  - 0xF0 -> BRK_E0.
  - Otherwise it is a make with ext=1.
- Make handling:
  - 0x12 or 0x59 with ext=0: set shift_held, go to IDLE, no event.
  - REPEAT_FILTER=1 and {code,ext} equals {last_make,last_ext}: drop, go to IDLE.
  - Otherwise: last_make<=code, last_ext<=ext, rom_addr<=code, go to LOOKUP.
- BRK or BRK_E0, on a byte (ext = 0 in BRK, 1 in BRK_E0):
  - If the byte is a Shift code and ext=0, clear shift_held.
  - If {byte,ext} equals {last_make,last_ext}, set last_make=0x00.
  - Go to IDLE. No event.
- LOOKUP: rom_rd=1 for exactly one cycle, then go to PUSH.
- PUSH: rom_data is valid.
  - rom_data==0x00: drop silently.
  - Otherwise ascii = rom_data, minus 0x20 if shift_held and rom_data is in 0x61..0x7A.
  - Push {ascii,ext} into the FIFO, then go to IDLE.
- Latency: a make byte strobed in cycle T gives rom_rd in T+1 and the push at the end of T+2. key_valid rises in T+3 if the FIFO was empty.
- Bytes arriving in LOOKUP/PUSH go into a one-entry hold register and are consumed as the next byte on return to IDLE, in the cycle after PUSH. A byte arriving while the hold register is full is lost and sets overflow.
- FIFO:
  - Head appears on key_ascii/key_extended.
  - Pop on key_valid && key_ready.
  - Push when full and no pop in the same cycle: event dropped, overflow=1, contents unchanged.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- key_ascii/key_extended hold their value when the FIFO is empty; they are don't-care while key_valid=0.
- overflow is cleared only by reset.

Test Plan:
- Reset, ROM[0x1C]=0x61, strobe 0x1C at T -> rom_rd=1/rom_addr=0x1C at T+1; key_valid=1, key_ascii=0x61, key_extended=0 at T+3; key_ready pulse -> key_valid=0.
- Bytes 12,1C,F0,1C,F0,12 -> exactly one event 0x41; shift_held 1 after 12, 0 after F0 12.
- Bytes 1C,1C,1C,F0,1C,1C with REPEAT_FILTER=1 -> exactly two 0x61 events; with REPEAT_FILTER=0 -> four events.
- ROM[0x75]=0x38, bytes E0,75 then E0,F0,75 -> one event 0x38 with key_extended=1; the break produces nothing. Unmapped code 0x07 (ROM=0) -> no event.
- key_ready=0, five distinct makes, FIFO_DEPTH=4 -> four events held, fifth dropped, overflow=1. Then a push with key_ready=1 while full -> accepted, count stays 4.
- Byte strobed during LOOKUP -> processed after PUSH. Reset asserted during PUSH -> no event, all outputs at reset values the next cycle.
